load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; all state SHALL clear immediately on reset assertion.
REQ-002 ADDR_W, default 10, SHALL set the word-address width of the data SRAM (2^ADDR_W 32-bit words).
REQ-003 clk  in  1  single clock; all logic SHALL use the rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 req_valid  in  1  a request is present.
REQ-006 req_ready  out  1  the block accepts a request; a transfer occurs when req_valid and req_ready are both 1 at a rising edge.
REQ-007 MemRW  in  1  1=store, 0=load, from the control unit.
REQ-008 WSel  in  2  store width: 00 byte, 01 half, 10 word, 11 none.
REQ-009 RSel  in  3  load type: 000 LB, 010 LH, 011 LW, 100 LBU, 101 LHU, 111 none; other codes SHALL be treated as none.
REQ-010 addr  in  32  byte address; bits [ADDR_W+1:2] select the word and [1:0] the byte lane.
REQ-011 wdata  in  32  store data, with the significant bits LSB-aligned.
REQ-012 resp_valid  out  1  one-cycle completion pulse.
REQ-013 rdata  out  32  load result, valid when resp_valid=1.
REQ-014 misalign  out  1  misaligned access flag, valid when resp_valid=1.
REQ-015 mem_en, mem_we  out  1 each  SRAM enable and write enable.
REQ-016 mem_addr  out  ADDR_W  SRAM word address.
REQ-017 mem_wdata  out  32  SRAM write data.
REQ-018 mem_rdata  in  32  SRAM read data, valid one cycle after a read-enable cycle.

Function
REQ-019 Request fields SHALL be captured on acceptance; the inputs are don't-care afterwards.
REQ-020 The FSM SHALL have states IDLE, RD, MERGE, WR, LDCAP, RESP; req_ready SHALL be 1 only in IDLE.
REQ-021 On a load accepted at edge T, the block SHALL drive RD in cycle T+1 (mem_en=1, mem_we=0), LDCAP in T+2, and RESP in T+3.
REQ-022 In LDCAP, the block SHALL select the addressed byte or half and sign-extend it (LB, LH) or zero-extend it (LBU, LHU); LW SHALL pass the word through.
REQ-023 A word store SHALL go IDLE->WR (mem_en=1, mem_we=1, mem_wdata=wdata) in T+1, then RESP in T+2.
REQ-024 A byte or half store SHALL perform read-modify-write: RD in T+1, MERGE in T+2 (replace the addressed lanes of mem_rdata with wdata low bits), WR in T+3, RESP in T+4.
REQ-025 A half access with addr[0]=1, or a word access with addr[1:0]!=00, SHALL skip memory (mem_en=0), go directly to RESP, and report misalign=1 with rdata=0.
REQ-026 A no-op (load with RSel none, or store with WSel none) SHALL go directly to RESP with misalign=0, rdata=0, and no memory access.
REQ-027 RESP SHALL last exactly one cycle with resp_valid=1 and then return to IDLE; there SHALL be no response backpressure.
REQ-028 rdata SHALL be 0 for stores; rdata and misalign SHALL hold their value outside RESP.
REQ-029 mem_en SHALL be 1 only in RD and WR; mem_we SHALL be 1 only in WR.
REQ-030 Address bits above ADDR_W+1 SHALL be ignored, so the address space wraps.
REQ-031 The next request SHALL be accepted no earlier than the cycle after RESP; back-to-back loads therefore issue one every 4 cycles.

Reset
REQ-032 On reset, the FSM SHALL be in IDLE and all outputs SHALL be 0 except req_ready=1; any in-flight operation SHALL be abandoned.
REQ-033 Reset asserted in MERGE or WR SHALL drop mem_we immediately, with no partial write committed afterwards.

Structure
REQ-034 The WSel/RSel encodings and FSM state enumeration SHALL live in a shared package used with the control unit.
REQ-035 Lane extract/extend and lane merge SHALL be one combinational sub-module, lsu_lane_align.

Verification
REQ-036 Store word 0xDEADBEEF to addr 0x10, then LW from 0x10 -> resp_valid at T+2 and T+3 respectively; rdata=0xDEADBEEF.
REQ-037 Store byte 0x80 to addr 0x13 over word 0x11223344 -> memory holds 0x80223344; LB returns 0xFFFFFF80; LBU returns 0x00000080.
REQ-038 LH from addr 0x11 -> no mem_en pulse; RESP at T+1 with misalign=1 and rdata=0.
REQ-039 Store half 0xABCD to addr 0x22 with rst_n pulsed low in MERGE -> no write occurs, FSM is in IDLE, and req_ready=1.
REQ-040 Load with RSel=111 and store with WSel=11 -> resp_valid at T+1, no memory access, misalign=0.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit and the control unit: store/load select codes,
// LSU FSM states, and the access-size decode used by the datapath.
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        WselByte = 2'b00,
        WselHalf = 2'b01,
        WselWord = 2'b10,
        WselNone = 2'b11
    } wsel_e;

    typedef enum logic [2:0] {
        RselLb   = 3'b000,
        RselLh   = 3'b010,
        RselLw   = 3'b011,
        RselLbu  = 3'b100,
        RselLhu  = 3'b101,
        RselNone = 3'b111
    } rsel_e;

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StMerge,
        StWr,
        StLdcap,
        StResp
    } lsu_state_e;

    typedef enum logic [1:0] {
        SzNone,
        SzByte,
        SzHalf,
        SzWord
    } acc_size_e;

    typedef struct packed {
        acc_size_e size;
        logic      sign_ext;
    } acc_kind_t;

    // Unlisted RSel codes fall through to SzNone and behave as a no-op.
    function automatic acc_kind_t decode_access(input logic       mem_rw,
                                                input logic [1:0] wsel,
                                                input logic [2:0] rsel);
        acc_kind_t k;
        k.size     = SzNone;
        k.sign_ext = 1'b0;
        if (mem_rw) begin
            case (wsel)
                WselByte: k.size = SzByte;
                WselHalf: k.size = SzHalf;
                WselWord: k.size = SzWord;
                default:  k.size = SzNone;
            endcase
        end else begin
            case (rsel)
                RselLb:  begin k.size = SzByte; k.sign_ext = 1'b1; end
                RselLh:  begin k.size = SzHalf; k.sign_ext = 1'b1; end
                RselLw:  k.size = SzWord;
                RselLbu: k.size = SzByte;
                RselLhu: k.size = SzHalf;
                default: k.size = SzNone;
            endcase
        end
        return k;
    endfunction

    function automatic logic is_misaligned(input acc_size_e size, input logic [1:0] lane);
        return ((size == SzHalf) && lane[0]) || ((size == SzWord) && (lane != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane datapath: extracts and extends load data from a memory word, and merges
// narrow store data into a memory word for read-modify-write.
module lsu_lane_align
    import load_store_unit_pkg::*;
(
    input  acc_size_e   size,
    input  logic        sign_ext,
    input  logic [1:0]  lane,
    input  logic [31:0] mem_word,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [31:0] shifted;

    always_comb begin
        shifted   = mem_word >> {lane, 3'b000};
        load_data = '0;
        case (size)
            SzByte:  load_data = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
            SzHalf:  load_data = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
            SzWord:  load_data = mem_word;
            default: load_data = '0;
        endcase
    end

    always_comb begin
        merge_data = mem_word;
        case (size)
            SzByte:  merge_data[{lane, 3'b000} +: 8]      = store_data[7:0];
            SzHalf:  merge_data[{lane[1], 4'b0000} +: 16] = store_data[15:0];
            SzWord:  merge_data = store_data;
            default: merge_data = mem_word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time against a single-port 32-bit SRAM with one-cycle read
// latency; narrow stores use read-modify-write, misaligned and no-op requests skip memory.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              MemRW,
    input  logic [1:0]        WSel,
    input  logic [2:0]        RSel,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              resp_valid,
    output logic [31:0]       rdata,
    output logic              misalign,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    lsu_state_e        state_q, state_d;
    logic              store_q, store_d;
    acc_size_e         size_q, size_d;
    logic              sign_q, sign_d;
    logic [1:0]        lane_q, lane_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              misalign_q, misalign_d;

    acc_kind_t   acc;
    logic        req_misal;
    logic [31:0] load_data;
    logic [31:0] merge_data;

    // Address bits above the SRAM word index are intentionally dropped so the space wraps.
    logic unused_addr;
    assign unused_addr = ^addr[31:ADDR_W+2];

    assign acc       = decode_access(MemRW, WSel, RSel);
    assign req_misal = is_misaligned(acc.size, addr[1:0]);

    lsu_lane_align u_lane_align (
        .size       (size_q),
        .sign_ext   (sign_q),
        .lane       (lane_q),
        .mem_word   (mem_rdata),
        .store_data (data_q),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    always_comb begin
        state_d    = state_q;
        store_d    = store_q;
        size_d     = size_q;
        sign_d     = sign_q;
        lane_d     = lane_q;
        addr_d     = addr_q;
        data_d     = data_q;
        rdata_d    = rdata_q;
        misalign_d = misalign_q;

        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    store_d = MemRW;
                    size_d  = acc.size;
                    sign_d  = acc.sign_ext;
                    lane_d  = addr[1:0];
                    addr_d  = addr[ADDR_W+1:2];
                    data_d  = wdata;
                    if ((acc.size == SzNone) || req_misal) begin
                        state_d    = StResp;
                        rdata_d    = '0;
                        misalign_d = req_misal;
                    end else if (MemRW && (acc.size == SzWord)) begin
                        state_d = StWr;
                    end else begin
                        state_d = StRd;
                    end
                end
            end
            StRd:    state_d = store_q ? StMerge : StLdcap;
            StMerge: begin
                // data_q now carries the full merged word for the write cycle.
                data_d  = merge_data;
                state_d = StWr;
            end
            StWr: begin
                rdata_d    = '0;
                misalign_d = 1'b0;
                state_d    = StResp;
            end
            StLdcap: begin
                rdata_d    = load_data;
                misalign_d = 1'b0;
                state_d    = StResp;
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            store_q    <= 1'b0;
            size_q     <= SzNone;
            sign_q     <= 1'b0;
            lane_q     <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            rdata_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            store_q    <= store_d;
            size_q     <= size_d;
            sign_q     <= sign_d;
            lane_q     <= lane_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            rdata_q    <= rdata_d;
            misalign_q <= misalign_d;
        end
    end

    // Memory strobes decode straight from state so reset kills a pending write at once.
    assign req_ready  = (state_q == StIdle);
    assign resp_valid = (state_q == StResp);
    assign mem_en     = (state_q == StRd) || (state_q == StWr);
    assign mem_we     = (state_q == StWr);
    assign mem_addr   = addr_q;
    assign mem_wdata  = (state_q == StWr) ? data_q : '0;
    assign rdata      = rdata_q;
    assign misalign   = misalign_q;

endmodule
